vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the VGA path: divides clk down to the pixel rate, runs horizontal/vertical
//  counters, and drives vga_h_sync, vga_v_sync, in_display_area plus pixel coordinates. Sits directly
//  upstream of the picture generator, which consumes in_display_area/pixel_x/pixel_y to choose RGB.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel (>=1); 2 gives 25 MHz pixels from 50 MHz clk
//  H_VISIBLE 640  visible pixels per line
//  H_FRONT   16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BACK    48   horizontal back porch (pixels); H_TOTAL = sum of H_* = 800, must be <= 1024
//  V_VISIBLE 480  visible lines per frame
//  V_FRONT   10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BACK    33   vertical back porch (lines); V_TOTAL = sum of V_* = 525, must be <= 1024
//  SYNC_POL  0    active level of both syncs (0 = active-low)
// PORTS
//  clk             in  1   system clock; sole clock domain
//  reset           in  1   synchronous, active-high reset
//  pix_tick        out 1   one-clk pulse marking each pixel advance
//  vga_h_sync      out 1   horizontal sync, level per SYNC_POL
//  vga_v_sync      out 1   vertical sync, level per SYNC_POL
//  in_display_area out 1   1 while pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
//  pixel_x         out 10  horizontal count, 0..H_TOTAL-1
//  pixel_y         out 10  vertical count, 0..V_TOTAL-1
//  line_start      out 1   one-clk pulse on the tick where pixel_x becomes 0
//  frame_start     out 1   one-clk pulse on the tick where (pixel_x,pixel_y) becomes (0,0)
// BEHAVIOUR
//  - All outputs registered; no combinational path from any input to any output.
//  - Reset (sampled at clk edge, wins over all else, may arrive mid-frame): divider=0, pixel_x=H_TOTAL-1,
//    pixel_y=V_TOTAL-1, pix_tick=0, line_start=0, frame_start=0, in_display_area=0, syncs inactive (!SYNC_POL).
//  - Divider counts 0..CLK_DIV-1, wraps to 0; pix_tick=1 for the clk cycle after divider reaches CLK_DIV-1.
//    CLK_DIV=1: pix_tick=1 every cycle after reset deasserts. First tick is CLK_DIV cycles after reset release.
//  - On the tick edge: pixel_x = (pixel_x==H_TOTAL-1) ? 0 : pixel_x+1; pixel_y advances only when pixel_x
//    wraps, and wraps itself from V_TOTAL-1 to 0. Between ticks all counters and levels hold.
//  - Syncs, in_display_area, line_start, frame_start are decoded from the NEXT count and registered in the
//    same edge, so they are cycle-aligned with pixel_x/pixel_y (zero skew, no pipeline lag).
//  - vga_h_sync = SYNC_POL iff H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC, else !SYNC_POL.
//  - vga_v_sync = SYNC_POL iff V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC (whole lines).
//  - line_start/frame_start high exactly one clk (the tick cycle), even when CLK_DIV>1; frame_start implies
//    line_start. First tick after reset yields (0,0) with both pulses and in_display_area=1.
//  - Period: H_TOTAL ticks per line, H_TOTAL*V_TOTAL ticks per frame; no drift, no skipped counts.
// TESTING
//  1. Defaults, release reset -> pix_tick at clk 2,4,6..; at clk 2: pixel=(0,0), frame_start=line_start=1,
//     in_display_area=1, both syncs 1; at clk 4 pulses 0, pixel_x=1.
//  2. Line 0 sweep -> in_display_area falls at pixel_x=640; vga_h_sync 0 for pixel_x 656..751 (96 ticks),
//     1 at 655 and 752; vga_v_sync stays 1.
//  3. pixel_x 799 -> next tick pixel_x=0, pixel_y+1, line_start one clk; line_start spacing = 1600 clk.
//  4. Full frame -> vga_v_sync 0 for pixel_y 490..491 only; (799,524) -> (0,0) with frame_start;
//     frame_start spacing = 840000 clk (420000 ticks); exactly 307200 ticks with in_display_area=1.
//  5. Assert reset 1 clk at (300,200) -> next clk all outputs at reset values; restart matches test 1.
//  6. CLK_DIV=1, SYNC_POL=1 -> pix_tick constant 1; syncs active-high on the same count windows;
//     frame_start spacing = 420000 clk.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle from the VGA timing generator to the
//               picture generator (sync levels, display window, coordinates
//               and line/frame/pixel strobes).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic       pix_tick;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       in_display_area;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;

  // Timing source side
  modport master (
    output pix_tick, vga_h_sync, vga_v_sync, in_display_area,
           pixel_x, pixel_y, line_start, frame_start
  );

  // Picture generator side
  modport slave (
    input  pix_tick, vga_h_sync, vga_v_sync, in_display_area,
           pixel_x, pixel_y, line_start, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Divides clk to the pixel rate and runs horizontal/vertical
//               raster counters. Syncs, display window and line/frame pulses
//               are decoded from the next count so every output changes on
//               the same edge as the coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // A one-bit divider is kept even for CLK_DIV=1; it then simply stays at 0.
  localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [9:0]  c_h_last  = 10'(c_h_total - 1);
  localparam logic [9:0]  c_v_last  = 10'(c_v_total - 1);
  // Window bounds are 11 bits so a sync ending exactly at 1024 still compares.
  localparam logic [10:0] c_h_vis   = 11'(H_VISIBLE);
  localparam logic [10:0] c_hs_beg  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] c_hs_end  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] c_v_vis   = 11'(V_VISIBLE);
  localparam logic [10:0] c_vs_beg  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] c_vs_end  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        c_act     = (SYNC_POL != 0);

  logic [c_div_w-1:0] div_q, div_d;
  logic [9:0]         pixel_x_q, pixel_x_d;
  logic [9:0]         pixel_y_q, pixel_y_d;
  logic               pix_tick_q;
  logic               h_sync_q, h_sync_d;
  logic               v_sync_q, v_sync_d;
  logic               disp_q, disp_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               w_tick;
  logic               w_h_wrap;
  logic [10:0]        w_x_ext;
  logic [10:0]        w_y_ext;

  // Clock divider: strobe on the last divider state, then wrap to 0
  always_comb begin
    w_tick = (div_q == c_div_last);
    div_d  = w_tick ? '0 : div_q + 1'b1;
  end

  // Next raster position and the levels/pulses that belong to it
  always_comb begin
    w_h_wrap  = (pixel_x_q == c_h_last);
    pixel_x_d = w_h_wrap ? 10'd0 : pixel_x_q + 10'd1;
    pixel_y_d = pixel_y_q;
    if (w_h_wrap) begin
      pixel_y_d = (pixel_y_q == c_v_last) ? 10'd0 : pixel_y_q + 10'd1;
    end
    w_x_ext       = {1'b0, pixel_x_d};
    w_y_ext       = {1'b0, pixel_y_d};
    h_sync_d      = ((w_x_ext >= c_hs_beg) && (w_x_ext < c_hs_end)) ? c_act : ~c_act;
    v_sync_d      = ((w_y_ext >= c_vs_beg) && (w_y_ext < c_vs_end)) ? c_act : ~c_act;
    disp_d        = (w_x_ext < c_h_vis) && (w_y_ext < c_v_vis);
    line_start_d  = (pixel_x_d == 10'd0);
    frame_start_d = line_start_d && (pixel_y_d == 10'd0);
  end

  // State update: counters and levels advance only on a pixel tick, pulses last one clk
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      pixel_x_q     <= c_h_last;
      pixel_y_q     <= c_v_last;
      pix_tick_q    <= 1'b0;
      h_sync_q      <= ~c_act;
      v_sync_q      <= ~c_act;
      disp_q        <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= w_tick;
      line_start_q  <= w_tick & line_start_d;
      frame_start_q <= w_tick & frame_start_d;
      if (w_tick) begin
        pixel_x_q <= pixel_x_d;
        pixel_y_q <= pixel_y_d;
        h_sync_q  <= h_sync_d;
        v_sync_q  <= v_sync_d;
        disp_q    <= disp_d;
      end
    end
  end

  assign vga.pix_tick        = pix_tick_q;
  assign vga.vga_h_sync      = h_sync_q;
  assign vga.vga_v_sync      = v_sync_q;
  assign vga.in_display_area = disp_q;
  assign vga.pixel_x         = pixel_x_q;
  assign vga.pixel_y         = pixel_y_q;
  assign vga.line_start      = line_start_q;
  assign vga.frame_start     = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. A closed-form raster
//               model (position derived from clocks since reset release)
//               feeds a scoreboard; scenario tasks add targeted checks.
//               Instance a uses defaults, b and c use small rasters so whole
//               frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   prm [3][10];   // D, HV, HF, HS, HB, VV, VF, VS, VB, POL
  int   k_cnt [3];
  exp_t sb [$];
  int   bad_cnt;
  int   bad_k;
  exp_t bad_o, bad_e, last_obs;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();
  vga_timing_gen_if vif_c ();

  vga_timing_gen dut_a (.clk(clk), .reset(rst_a), .vga(vif_a));

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
  ) dut_b (.clk(clk), .reset(rst_b), .vga(vif_b));

  vga_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(1), .V_BACK(2), .SYNC_POL(0)
  ) dut_c (.clk(clk), .reset(rst_c), .vga(vif_c));

  always #5 clk = ~clk;

  // Expected outputs after the k-th clk edge since reset release (k=0: in reset)
  function automatic exp_t model(input int sel, input int k);
    int d, hv, hf, hsw, vv, vf, vsw, ht, vt, n, p, x, y;
    logic act;
    exp_t e;
    d   = prm[sel][0];
    hv  = prm[sel][1]; hf = prm[sel][2]; hsw = prm[sel][3];
    vv  = prm[sel][5]; vf = prm[sel][6]; vsw = prm[sel][7];
    ht  = hv + hf + hsw + prm[sel][4];
    vt  = vv + vf + vsw + prm[sel][8];
    act = (prm[sel][9] != 0);
    n   = k / d;
    if (n == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      p = (n - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
    end
    e.tick = (k > 0) && (k % d == 0);
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.de   = (n > 0) && (x < hv) && (y < vv);
    e.hs   = ((n > 0) && (x >= hv + hf) && (x < hv + hf + hsw)) ? act : !act;
    e.vs   = ((n > 0) && (y >= vv + vf) && (y < vv + vf + vsw)) ? act : !act;
    e.ls   = e.tick && (x == 0);
    e.fs   = e.ls && (y == 0);
    return e;
  endfunction

  function automatic exp_t obs(input int sel);
    case (sel)
      0: obs = {vif_a.pix_tick, vif_a.vga_h_sync, vif_a.vga_v_sync, vif_a.in_display_area,
                vif_a.line_start, vif_a.frame_start, vif_a.pixel_x, vif_a.pixel_y};
      1: obs = {vif_b.pix_tick, vif_b.vga_h_sync, vif_b.vga_v_sync, vif_b.in_display_area,
                vif_b.line_start, vif_b.frame_start, vif_b.pixel_x, vif_b.pixel_y};
      default: obs = {vif_c.pix_tick, vif_c.vga_h_sync, vif_c.vga_v_sync, vif_c.in_display_area,
                vif_c.line_start, vif_c.frame_start, vif_c.pixel_x, vif_c.pixel_y};
    endcase
  endfunction

  task automatic set_rst(input int sel, input logic v);
    case (sel)
      0: rst_a = v;
      1: rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  // One clk: push the model's prediction at the edge, pop and compare mid-cycle
  task automatic step(input int sel, input bit in_rst);
    exp_t e, o;
    @(posedge clk);
    if (in_rst) k_cnt[sel] = 0;
    else        k_cnt[sel] = k_cnt[sel] + 1;
    sb.push_back(model(sel, k_cnt[sel]));
    @(negedge clk);
    e = sb.pop_front();
    o = obs(sel);
    last_obs = o;
    if (o !== e) begin
      if (bad_cnt == 0) begin
        bad_k = k_cnt[sel];
        bad_o = o;
        bad_e = e;
      end
      bad_cnt++;
    end
  endtask

  task automatic test_reset();
    exp_t c;
    bad_cnt = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    step(0, 1);
    step(0, 1);
    c = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd799, 10'd524};
    n_tests++;
    if (last_obs !== c) begin
      n_fail++;
      $display("FAIL reset_a: got %h want %h", last_obs, c);
    end
    c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd14, 10'd9};
    n_tests++;
    if (obs(1) !== c) begin
      n_fail++;
      $display("FAIL reset_b_pol1: got %h want %h", obs(1), c);
    end
  endtask

  task automatic test_first_ticks();
    exp_t c;
    rst_a = 1'b0;
    step(0, 0);
    c = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd799, 10'd524};
    n_tests++;
    if (last_obs !== c) begin n_fail++; $display("FAIL clk1_hold: got %h want %h", last_obs, c); end
    step(0, 0);
    c = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
    n_tests++;
    if (last_obs !== c) begin n_fail++; $display("FAIL clk2_first_tick: got %h want %h", last_obs, c); end
    step(0, 0);
    c = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    n_tests++;
    if (last_obs !== c) begin n_fail++; $display("FAIL clk3_between: got %h want %h", last_obs, c); end
    step(0, 0);
    c = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd1, 10'd0};
    n_tests++;
    if (last_obs !== c) begin n_fail++; $display("FAIL clk4_second_tick: got %h want %h", last_obs, c); end
  endtask

  task automatic test_line_sweep();
    int de_fall = -1, hs_n = 0, hs_first = -1, hs_last = -1, vs_low = 0;
    while (k_cnt[0] < 1600) begin
      step(0, 0);
      if (last_obs.tick) begin
        if (!last_obs.de && de_fall < 0) de_fall = int'(last_obs.x);
        if (!last_obs.hs) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(last_obs.x);
          hs_last = int'(last_obs.x);
        end
        if (!last_obs.vs) vs_low++;
      end
    end
    n_tests++;
    if (de_fall !== 640) begin n_fail++; $display("FAIL de_fall_x: got %0d want 640", de_fall); end
    n_tests++;
    if (hs_n !== 96) begin n_fail++; $display("FAIL hsync_ticks: got %0d want 96", hs_n); end
    n_tests++;
    if (hs_first !== 656) begin n_fail++; $display("FAIL hsync_first_x: got %0d want 656", hs_first); end
    n_tests++;
    if (hs_last !== 751) begin n_fail++; $display("FAIL hsync_last_x: got %0d want 751", hs_last); end
    n_tests++;
    if (vs_low !== 0) begin n_fail++; $display("FAIL vsync_line0: got %0d low ticks want 0", vs_low); end
  endtask

  task automatic test_line_wrap();
    exp_t c;
    int ls_n = 0, ls_k = -1;
    n_tests++;
    if ({last_obs.x, last_obs.y} !== {10'd799, 10'd0}) begin
      n_fail++;
      $display("FAIL line_end_xy: got (%0d,%0d) want (799,0)", last_obs.x, last_obs.y);
    end
    step(0, 0);
    step(0, 0);
    c = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd1};
    n_tests++;
    if (last_obs !== c) begin n_fail++; $display("FAIL line_wrap: got %h want %h", last_obs, c); end
    step(0, 0);
    n_tests++;
    if (last_obs.ls !== 1'b0) begin n_fail++; $display("FAIL line_start_width: got %b want 0", last_obs.ls); end
    while (k_cnt[0] < 3202) begin
      step(0, 0);
      if (last_obs.ls) begin ls_n++; ls_k = k_cnt[0]; end
    end
    n_tests++;
    if (ls_k - 1602 !== 1600) begin n_fail++; $display("FAIL line_spacing: got %0d want 1600", ls_k - 1602); end
    n_tests++;
    if (ls_n !== 1) begin n_fail++; $display("FAIL line_start_count: got %0d want 1", ls_n); end
    n_tests++;
    if (bad_cnt !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_a: %0d cycles, first k=%0d got %h want %h", bad_cnt, bad_k, bad_o, bad_e);
    end
  endtask

  task automatic test_frame(input int sel);
    int d, hv, vv, vf, hsw, vsw, ht, vt, f, fs1, fs2, de_n, vs_n, hs_n, vs_min, vs_max;
    int notick, prev_x, prev_y, wrap_x, wrap_y, ncyc;
    logic act;
    d   = prm[sel][0];
    hv  = prm[sel][1]; hsw = prm[sel][3];
    vv  = prm[sel][5]; vf  = prm[sel][6]; vsw = prm[sel][7];
    ht  = hv + prm[sel][2] + hsw + prm[sel][4];
    vt  = vv + vf + vsw + prm[sel][8];
    act = (prm[sel][9] != 0);
    f   = ht * vt * d;
    ncyc = 2 * f + 2;
    fs1 = -1; fs2 = -1; de_n = 0; vs_n = 0; hs_n = 0; vs_min = 1024; vs_max = -1;
    notick = 0; prev_x = -1; prev_y = -1; wrap_x = -1; wrap_y = -1;
    bad_cnt = 0;
    set_rst(sel, 1'b1);
    step(sel, 1);
    set_rst(sel, 1'b0);
    for (int i = 0; i < ncyc; i++) begin
      step(sel, 0);
      if (!last_obs.tick) notick++;
      else begin
        if (last_obs.fs) begin
          if (fs1 < 0) fs1 = k_cnt[sel];
          else if (fs2 < 0) begin fs2 = k_cnt[sel]; wrap_x = prev_x; wrap_y = prev_y; end
        end
        if (k_cnt[sel] <= f) begin
          if (last_obs.de) de_n++;
          if (last_obs.hs === act) hs_n++;
          if (last_obs.vs === act) begin
            vs_n++;
            if (int'(last_obs.y) < vs_min) vs_min = int'(last_obs.y);
            if (int'(last_obs.y) > vs_max) vs_max = int'(last_obs.y);
          end
        end
        prev_x = int'(last_obs.x);
        prev_y = int'(last_obs.y);
      end
    end
    n_tests++;
    if (fs1 !== d) begin n_fail++; $display("FAIL frame%0d_first: got k=%0d want %0d", sel, fs1, d); end
    n_tests++;
    if (fs2 - fs1 !== f) begin n_fail++; $display("FAIL frame%0d_spacing: got %0d want %0d", sel, fs2 - fs1, f); end
    n_tests++;
    if ({wrap_x, wrap_y} !== {ht - 1, vt - 1}) begin
      n_fail++;
      $display("FAIL frame%0d_wrap_from: got (%0d,%0d) want (%0d,%0d)", sel, wrap_x, wrap_y, ht - 1, vt - 1);
    end
    n_tests++;
    if (de_n !== hv * vv) begin n_fail++; $display("FAIL frame%0d_display_ticks: got %0d want %0d", sel, de_n, hv * vv); end
    n_tests++;
    if (hs_n !== hsw * vt) begin n_fail++; $display("FAIL frame%0d_hsync_ticks: got %0d want %0d", sel, hs_n, hsw * vt); end
    n_tests++;
    if (vs_n !== vsw * ht) begin n_fail++; $display("FAIL frame%0d_vsync_ticks: got %0d want %0d", sel, vs_n, vsw * ht); end
    n_tests++;
    if (vs_min !== vv + vf) begin n_fail++; $display("FAIL frame%0d_vsync_first_y: got %0d want %0d", sel, vs_min, vv + vf); end
    n_tests++;
    if (vs_max !== vv + vf + vsw - 1) begin
      n_fail++;
      $display("FAIL frame%0d_vsync_last_y: got %0d want %0d", sel, vs_max, vv + vf + vsw - 1);
    end
    n_tests++;
    if (notick !== ncyc - ncyc / d) begin
      n_fail++;
      $display("FAIL frame%0d_idle_cycles: got %0d want %0d", sel, notick, ncyc - ncyc / d);
    end
    n_tests++;
    if (bad_cnt !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_%0d: %0d cycles, first k=%0d got %h want %h", sel, bad_cnt, bad_k, bad_o, bad_e);
    end
  endtask

  task automatic test_mid_reset(input int sel, input int tx, input int ty);
    int d, ht, vt, f;
    bit found;
    logic act;
    exp_t rv, c;
    d   = prm[sel][0];
    ht  = prm[sel][1] + prm[sel][2] + prm[sel][3] + prm[sel][4];
    vt  = prm[sel][5] + prm[sel][6] + prm[sel][7] + prm[sel][8];
    act = (prm[sel][9] != 0);
    f   = ht * vt * d;
    rv  = {1'b0, !act, !act, 1'b0, 1'b0, 1'b0, 10'(ht - 1), 10'(vt - 1)};
    bad_cnt = 0;
    found = 1'b0;
    set_rst(sel, 1'b1);
    step(sel, 1);
    set_rst(sel, 1'b0);
    for (int i = 0; i < f && !found; i++) begin
      step(sel, 0);
      if (last_obs.tick && int'(last_obs.x) == tx && int'(last_obs.y) == ty) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL mid_reset_reach: got found=%0b want 1", found); end
    step(sel, 0);
    set_rst(sel, 1'b1);
    step(sel, 1);
    set_rst(sel, 1'b0);
    n_tests++;
    if (last_obs !== rv) begin n_fail++; $display("FAIL mid_reset_values: got %h want %h", last_obs, rv); end
    for (int i = 1; i < d; i++) step(sel, 0);
    n_tests++;
    if (last_obs !== rv) begin n_fail++; $display("FAIL restart_hold: got %h want %h", last_obs, rv); end
    step(sel, 0);
    c = {1'b1, !act, !act, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
    n_tests++;
    if (last_obs !== c) begin n_fail++; $display("FAIL restart_first_tick: got %h want %h", last_obs, c); end
    for (int i = 0; i < f; i++) step(sel, 0);
    n_tests++;
    if (bad_cnt !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_restart: %0d cycles, first k=%0d got %h want %h", bad_cnt, bad_k, bad_o, bad_e);
    end
  endtask

  initial begin
    prm[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0};
    prm[1] = '{1, 8, 2, 3, 2, 6, 1, 2, 1, 1};
    prm[2] = '{3, 5, 1, 2, 3, 4, 2, 1, 2, 0};
    k_cnt  = '{0, 0, 0};
    test_reset();
    test_first_ticks();
    test_line_sweep();
    test_line_wrap();
    test_frame(1);
    test_frame(2);
    test_mid_reset(2, 3, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
